// File: rtl/dac_load_sequencer.sv
// rtl/dac_load_sequencer.sv - DAC shadow RAM with dirty tracking and req/ack load sequencer (optional DAC_LOAD_ALL_EN)
module dac_load_sequencer #(
  parameter int ADDR_BITS    = 5,
  parameter int DAT_BITS     = 16,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 wr_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DAT_BITS-1:0]  wdat_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DAT_BITS-1:0]  rdat_o,
  input  logic                 update_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 dac_req_o,
  input  logic                 dac_ack_i,
  output logic [ADDR_BITS-1:0] dac_addr_o,
  output logic [DAT_BITS-1:0]  dac_dat_o,
  output logic                 timeout_o,
  input  logic                 clr_err_i,
  output logic [ADDR_BITS:0]   load_count_o
);

  localparam int NCH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_FETCH = 3'd2,
    ST_REQ   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Shadow copy of the DAC settings; starts at zero and is deliberately not reset
  logic [DAT_BITS-1:0] mem_q [NCH] = '{default: '0};

  state_t                  state_q, state_d;
  logic [ADDR_BITS-1:0]    scan_addr_q, scan_addr_d;
  logic [NCH-1:0]          dirty_q, dirty_d;
  logic                    pending_q, pending_d;
  logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_BITS:0]      pass_cnt_q, pass_cnt_d;

  logic [DAT_BITS-1:0]     rdat_q, rdat_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    req_q, req_d;
  logic [ADDR_BITS-1:0]    dac_addr_q, dac_addr_d;
  logic [DAT_BITS-1:0]     dac_dat_q, dac_dat_d;
  logic                    timeout_q, timeout_d;
  logic [ADDR_BITS:0]      load_count_q, load_count_d;

  logic [NCH-1:0]          dirty_clr;
  logic [NCH-1:0]          dirty_set;
  logic [NCH-1:0]          wr_set;
  logic                    tmo_evt;
  logic                    last_addr;
  logic                    scan_hit;

  assign last_addr = &scan_addr_q;

`ifdef DAC_LOAD_ALL_EN
  // Every channel is loaded on each pass; dirty bits are still kept up to date
  assign scan_hit = 1'b1;
`else
  assign scan_hit = dirty_q[scan_addr_q];
`endif

  // Host writes land in the shadow RAM; the sequencer only ever reads it
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[waddr_i] <= wdat_i;
    end
  end

  // Next-state logic for the load FSM, dirty vector, counters and registered outputs
  always_comb begin
    state_d      = state_q;
    scan_addr_d  = scan_addr_q;
    pending_d    = pending_q;
    tmo_cnt_d    = tmo_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    dac_addr_d   = dac_addr_q;
    dac_dat_d    = dac_dat_q;
    load_count_d = load_count_q;
    dirty_clr    = '0;
    dirty_set    = '0;
    wr_set       = '0;
    tmo_evt      = 1'b0;

    // Strobes arriving mid-pass collapse into one follow-up pass
    if (update_i && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (update_i) begin
          state_d     = ST_SCAN;
          scan_addr_d = '0;
          pass_cnt_d  = '0;
        end
      end

      ST_SCAN: begin
        if (scan_hit) begin
          state_d = ST_FETCH;
        end else if (last_addr) begin
          state_d = ST_DONE;
        end else begin
          scan_addr_d = scan_addr_q + ADDR_BITS'(1);
        end
      end

      ST_FETCH: begin
        // A write in this same cycle still re-dirties the channel, since set beats clear
        dac_addr_d             = scan_addr_q;
        dac_dat_d              = mem_q[scan_addr_q];
        dirty_clr[scan_addr_q] = 1'b1;
        tmo_cnt_d              = '0;
        state_d                = ST_REQ;
      end

      ST_REQ: begin
        if (dac_ack_i) begin
          pass_cnt_d = pass_cnt_q + (ADDR_BITS + 1)'(1);
          if (last_addr) begin
            state_d = ST_DONE;
          end else begin
            scan_addr_d = scan_addr_q + ADDR_BITS'(1);
            state_d     = ST_SCAN;
          end
        end else if (&tmo_cnt_q) begin
          // Driver never answered: flag it and keep the channel queued for the next pass
          tmo_evt                = 1'b1;
          dirty_set[scan_addr_q] = 1'b1;
          if (last_addr) begin
            state_d = ST_DONE;
          end else begin
            scan_addr_d = scan_addr_q + ADDR_BITS'(1);
            state_d     = ST_SCAN;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
        end
      end

      ST_DONE: begin
        if (pending_q || update_i) begin
          pending_d   = 1'b0;
          state_d     = ST_SCAN;
          scan_addr_d = '0;
          pass_cnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Publish the count together with the done pulse
    if (state_d == ST_DONE) begin
      load_count_d = pass_cnt_d;
    end

    if (wr_i) begin
      wr_set[waddr_i] = 1'b1;
    end
    dirty_d = (dirty_q & ~dirty_clr) | dirty_set | wr_set;

    if (tmo_evt) begin
      timeout_d = 1'b1;
    end else if (clr_err_i) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    req_d  = (state_d == ST_REQ);
    rdat_d = mem_q[raddr_i];
  end

  // State and output registers; reset abandons any pass and re-dirties every channel
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= ST_IDLE;
      scan_addr_q  <= '0;
      dirty_q      <= '1;
      pending_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      pass_cnt_q   <= '0;
      rdat_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_q        <= 1'b0;
      dac_addr_q   <= '0;
      dac_dat_q    <= '0;
      timeout_q    <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      scan_addr_q  <= scan_addr_d;
      dirty_q      <= dirty_d;
      pending_q    <= pending_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      rdat_q       <= rdat_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_q        <= req_d;
      dac_addr_q   <= dac_addr_d;
      dac_dat_q    <= dac_dat_d;
      timeout_q    <= timeout_d;
      load_count_q <= load_count_d;
    end
  end

  assign rdat_o       = rdat_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign dac_req_o    = req_q;
  assign dac_addr_o   = dac_addr_q;
  assign dac_dat_o    = dac_dat_q;
  assign timeout_o    = timeout_q;
  assign load_count_o = load_count_q;

endmodule

// File: tb/tb_dac_load_sequencer.sv
// tb/tb_dac_load_sequencer.sv - self-checking bench for dac_load_sequencer against a pass-level model
`timescale 1ns/1ps
module tb_dac_load_sequencer;
  localparam int AB  = 5;
  localparam int DB  = 16;
  localparam int TB  = 10;
  localparam int NCH = 32;

  logic          clk_i = 1'b0;
  logic          nrst_i = 1'b0;
  logic          wr_i = 1'b0;
  logic [AB-1:0] waddr_i = '0;
  logic [DB-1:0] wdat_i = '0;
  logic [AB-1:0] raddr_i = '0;
  logic [DB-1:0] rdat_o;
  logic          update_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          dac_req_o;
  logic          dac_ack_i = 1'b0;
  logic [AB-1:0] dac_addr_o;
  logic [DB-1:0] dac_dat_o;
  logic          timeout_o;
  logic          clr_err_i = 1'b0;
  logic [AB:0]   load_count_o;

  always #15 clk_i = ~clk_i;

  dac_load_sequencer #(.ADDR_BITS(AB), .DAT_BITS(DB), .TIMEOUT_BITS(TB)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .wr_i(wr_i), .waddr_i(waddr_i), .wdat_i(wdat_i),
    .raddr_i(raddr_i), .rdat_o(rdat_o), .update_i(update_i), .busy_o(busy_o),
    .done_o(done_o), .dac_req_o(dac_req_o), .dac_ack_i(dac_ack_i),
    .dac_addr_o(dac_addr_o), .dac_dat_o(dac_dat_o), .timeout_o(timeout_o),
    .clr_err_i(clr_err_i), .load_count_o(load_count_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: channel contents, pending-load set and sticky error
  logic [DB-1:0] model_mem [NCH];
  bit            model_dirty [NCH];
  bit            model_to;
  int            exp_cnt;
  int            exp_a[$];
  logic [DB-1:0] exp_d[$];

  int            obs_a[$];
  logic [DB-1:0] obs_d[$];
  int            req_len[$];
  int            done_cyc;
  bit            done_seen;
  bit            unstable;
  int            hook_addr = -1;
  logic [DB-1:0] hook_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DB-1:0] d);
    wr_i = 1'b1; waddr_i = AB'(a); wdat_i = d;
    step();
    wr_i = 1'b0;
    model_mem[a]   = d;
    model_dirty[a] = 1'b1;
  endtask

  // A pass visits dirty channels in ascending order; acked ones become clean, timed-out ones stay queued
  task automatic model_pass(input bit ack_en);
    exp_a.delete(); exp_d.delete(); exp_cnt = 0;
    for (int a = 0; a < NCH; a++) begin
      if (model_dirty[a]) begin
        exp_a.push_back(a);
        exp_d.push_back(model_mem[a]);
        if (ack_en) begin
          model_dirty[a] = 1'b0;
          exp_cnt++;
        end else begin
          model_to = 1'b1;
        end
      end
    end
  endtask

  task automatic run_pass(input bit do_upd, input int dly, input bit ack_en);
    int cyc; int age; int hook_t;
    logic [AB-1:0] cur_a; logic [DB-1:0] cur_d;
    obs_a.delete(); obs_d.delete(); req_len.delete();
    done_seen = 0; done_cyc = -1; unstable = 0; hook_t = 0; age = 0;
    cur_a = '0; cur_d = '0;
    if (do_upd) update_i = 1'b1;
    step();
    update_i = 1'b0;
    cyc = 1;
    check("busy_cycle1", busy_o, 1);
    while (!done_seen && cyc < 20000) begin
      if (dac_req_o) begin
        if (age == 0) begin
          obs_a.push_back(int'(dac_addr_o));
          obs_d.push_back(dac_dat_o);
          cur_a = dac_addr_o; cur_d = dac_dat_o;
          if (hook_addr >= 0 && int'(dac_addr_o) == hook_addr) hook_t = 1;
        end else if (dac_addr_o !== cur_a || dac_dat_o !== cur_d) begin
          unstable = 1;
        end
        age++;
        dac_ack_i = ack_en && (age == dly);
      end else begin
        if (age != 0) req_len.push_back(age);
        age = 0;
        dac_ack_i = 1'b0;
      end
      case (hook_t)
        1: begin
          wr_i = 1'b1; waddr_i = AB'(hook_addr); wdat_i = hook_data; update_i = 1'b1;
          model_mem[hook_addr] = hook_data; model_dirty[hook_addr] = 1'b1;
          hook_t = 2;
        end
        2: begin wr_i = 1'b0; update_i = 1'b0; hook_t = 3; end
        3: begin update_i = 1'b1; hook_t = 4; end
        4: begin update_i = 1'b0; hook_t = 0; hook_addr = -1; end
        default: ;
      endcase
      if (done_o) begin
        done_seen = 1; done_cyc = cyc;
      end else begin
        step();
        cyc++;
      end
    end
    dac_ack_i = 1'b0;
    check("pass_done_seen", done_seen, 1);
  endtask

  task automatic compare_pass(input string tag);
    check({tag, "_nreq"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), obs_a[i], exp_a[i]);
      check($sformatf("%s_data%0d", tag, i), obs_d[i], exp_d[i]);
    end
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_load_count"}, load_count_o, exp_cnt);
    check({tag, "_timeout"}, timeout_o, model_to);
  endtask

  initial begin
    int a; int nw; int dly;
    logic [DB-1:0] d; logic [DB-1:0] old;

    for (int i = 0; i < NCH; i++) begin model_mem[i] = '0; model_dirty[i] = 1'b1; end
    model_to = 1'b0;

    // Reset values
    step(); step(); step();
    check("rst_rdat", rdat_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_req", dac_req_o, 0);
    check("rst_addr", dac_addr_o, 0);
    check("rst_dat", dac_dat_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_load_count", load_count_o, 0);
    nrst_i = 1'b1;
    step();

    // First pass after reset loads every channel
    model_pass(1); run_pass(1, 1, 1); compare_pass("all32");
    step(); check("all32_idle", busy_o, 0);

    // Two modified channels only
    do_write(5, 16'h1234); do_write(30, 16'hBEEF);
    model_pass(1); run_pass(1, 1, 1); compare_pass("two_ch");
    step(); check("two_ch_idle", busy_o, 0);

    // Nothing dirty: scan timing only
    model_pass(1); run_pass(1, 1, 1); compare_pass("clean");
    check("clean_done_cycle", done_cyc, 33);
    check("clean_busy_at_done", busy_o, 1);
    step();
    check("clean_busy_c34", busy_o, 0);
    check("clean_done_c34", done_o, 0);

    // Ack never returned: timeout after 1024 request cycles
    do_write(3, 16'h0C0C);
    model_pass(0); run_pass(1, 1, 0); compare_pass("tmo");
    check("tmo_nlen", req_len.size(), 1);
    if (req_len.size() > 0) check("tmo_req_len", req_len[0], 1024);
    step(); check("tmo_idle", busy_o, 0);
    model_pass(1); run_pass(1, 2, 1); compare_pass("tmo_retry");
    step();
    clr_err_i = 1'b1; step(); clr_err_i = 1'b0; model_to = 1'b0;
    check("clr_err", timeout_o, 0);

    // Write to the in-flight channel plus two update strobes: one follow-up pass with the new value
    do_write(2, 16'h1111); do_write(9, 16'h2222);
    hook_addr = 2; hook_data = 16'h5A5A;
    model_pass(1); run_pass(1, 3, 1); compare_pass("inflight");
    check("inflight_busy_pending", busy_o, 1);
    model_pass(1); run_pass(0, 3, 1); compare_pass("followup");
    step();
    check("followup_only_one", busy_o, 0);

    // Readback, including same-cycle write returning old data
    old = model_mem[11];
    raddr_i = AB'(11); wr_i = 1'b1; waddr_i = AB'(11); wdat_i = 16'hA55A;
    step();
    wr_i = 1'b0;
    check("rd_old_on_write", rdat_o, old);
    model_mem[11] = 16'hA55A; model_dirty[11] = 1'b1;
    step();
    check("rd_new", rdat_o, 16'hA55A);

    // Randomized rounds
    for (int r = 0; r < 5; r++) begin
      nw = $urandom_range(0, 5);
      for (int k = 0; k < nw; k++) begin
        a = $urandom_range(0, NCH - 1);
        d = DB'($urandom);
        do_write(a, d);
      end
      for (int k = 0; k < 3; k++) begin
        a = $urandom_range(0, NCH - 1);
        raddr_i = AB'(a);
        step();
        check($sformatf("rand_rd%0d_%0d", r, k), rdat_o, model_mem[a]);
      end
      dly = $urandom_range(1, 4);
      model_pass(1); run_pass(1, dly, 1); compare_pass($sformatf("rand%0d", r));
      step(); check($sformatf("rand%0d_idle", r), busy_o, 0);
    end

    // Reset in the middle of a request
    do_write(7, 16'h7777);
    update_i = 1'b1; step(); update_i = 1'b0;
    for (int i = 0; i < 200 && !dac_req_o; i++) step();
    check("midrst_req_reached", dac_req_o, 1);
    nrst_i = 1'b0;
    #1;
    check("midrst_req_low", dac_req_o, 0);
    check("midrst_busy_low", busy_o, 0);
    step(); step();
    nrst_i = 1'b1;
    for (int i = 0; i < NCH; i++) model_dirty[i] = 1'b1;
    model_to = 1'b0;
    step();
    model_pass(1); run_pass(1, 1, 1); compare_pass("after_rst");
    step(); check("after_rst_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
